// File: rtl/timer_tick.sv
// Programmable one-shot/periodic down-counting timer advanced by an upstream prescaler tick.
// Optional overrun flag output `ovr` enabled by defining TIMER_TICK_OVERRUN_EN.
module timer_tick #(
    parameter int unsigned WIDTH          = 16,
    parameter bit          REPEAT_DEFAULT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             str,
    input  logic             stp,
    input  logic             clr,
    input  logic             rpt,
    input  logic [WIDTH-1:0] per,
    output logic [WIDTH-1:0] cnt,
    output logic             bsy,
    output logic             irq,
`ifdef TIMER_TICK_OVERRUN_EN
    output logic             sts,
    output logic             ovr
`else
    output logic             sts
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] per_q, per_d;
    logic             rpt_q, rpt_d;
    logic             bsy_q, bsy_d;
    logic             irq_q, irq_d;
    logic             sts_q, sts_d;
    logic             expire;
`ifdef TIMER_TICK_OVERRUN_EN
    logic             ovr_q, ovr_d;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            rpt_q   <= REPEAT_DEFAULT;
            bsy_q   <= 1'b0;
            irq_q   <= 1'b0;
            sts_q   <= 1'b0;
`ifdef TIMER_TICK_OVERRUN_EN
            ovr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            rpt_q   <= rpt_d;
            bsy_q   <= bsy_d;
            irq_q   <= irq_d;
            sts_q   <= sts_d;
`ifdef TIMER_TICK_OVERRUN_EN
            ovr_q   <= ovr_d;
`endif
        end
    end

    // Next state: stop beats start beats tick
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        rpt_d   = rpt_q;
        expire  = 1'b0;

        if (stp) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (str) begin
            per_d = per;
            rpt_d = rpt;
            if (per != '0) begin
                cnt_d   = per;
                state_d = ST_RUN;
            end else begin
                // Zero period expires at once and never enters RUN
                expire  = 1'b1;
                cnt_d   = '0;
                state_d = rpt ? ST_IDLE : ST_DONE;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ena) begin
                        if (cnt_q == WIDTH'(1)) begin
                            expire = 1'b1;
                            if (rpt_q) begin
                                cnt_d = per_q;
                            end else begin
                                cnt_d   = '0;
                                state_d = ST_DONE;
                            end
                        end else begin
                            cnt_d = cnt_q - WIDTH'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (clr) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        bsy_d = (state_d == ST_RUN);
        irq_d = expire;
        sts_d = expire ? 1'b1 : (clr ? 1'b0 : sts_q);
`ifdef TIMER_TICK_OVERRUN_EN
        // A clear in the same cycle as a repeat expiry still acknowledges the overrun
        ovr_d = clr ? 1'b0 : ((expire && sts_q) ? 1'b1 : ovr_q);
`endif
    end

    assign cnt = cnt_q;
    assign bsy = bsy_q;
    assign irq = irq_q;
    assign sts = sts_q;
`ifdef TIMER_TICK_OVERRUN_EN
    assign ovr = ovr_q;
`endif

endmodule

// File: tb/tb_timer_tick.sv
// Self-checking bench for timer_tick: directed edge cases plus randomized traffic
// compared each cycle against a behavioural timer model.
module tb_timer_tick;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0, str = 1'b0, stp = 1'b0, clr = 1'b0, rpt = 1'b0;
    logic [15:0] per = '0;
    logic [15:0] cnt;
    logic        bsy, irq, sts;
`ifdef TIMER_TICK_OVERRUN_EN
    logic        ovr;
`endif

    int unsigned checks = 0;
    int unsigned fails  = 0;

    // Behavioural model: running flag, remaining ticks, latched period/mode, flags
    bit          m_run = 0, m_periodic = 0, m_irq = 0, m_sts = 0, m_ovr = 0;
    int unsigned m_rem = 0, m_period = 0;

    timer_tick #(.WIDTH(16), .REPEAT_DEFAULT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .str(str), .stp(stp), .clr(clr),
        .rpt(rpt), .per(per), .cnt(cnt), .bsy(bsy), .irq(irq),
`ifdef TIMER_TICK_OVERRUN_EN
        .sts(sts), .ovr(ovr)
`else
        .sts(sts)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cnt"}, 32'(cnt), m_rem);
        check({tag, ".bsy"}, 32'(bsy), 32'(m_run));
        check({tag, ".irq"}, 32'(irq), 32'(m_irq));
        check({tag, ".sts"}, 32'(sts), 32'(m_sts));
`ifdef TIMER_TICK_OVERRUN_EN
        check({tag, ".ovr"}, 32'(ovr), 32'(m_ovr));
`endif
    endtask

    task automatic model_reset();
        m_run = 0; m_periodic = 0; m_irq = 0; m_sts = 0; m_ovr = 0;
        m_rem = 0; m_period = 0;
    endtask

    // One clock of the timer rules, written in terms of ticks remaining
    task automatic model_step(input bit e, input bit s, input bit p, input bit c,
                              input bit r, input int unsigned pr);
        bit fired = 0;
        if (p) begin
            m_run = 0; m_rem = 0;
        end else if (s) begin
            m_period = pr; m_periodic = r;
            if (pr == 0) begin
                fired = 1; m_run = 0; m_rem = 0;
            end else begin
                m_run = 1; m_rem = pr;
            end
        end else if (m_run && e) begin
            if (m_rem == 1) begin
                fired = 1;
                if (m_periodic) m_rem = m_period;
                else begin m_rem = 0; m_run = 0; end
            end else begin
                m_rem = m_rem - 1;
            end
        end
        if (c) m_ovr = 0;
        else if (fired && m_sts) m_ovr = 1;
        if (fired) m_sts = 1;
        else if (c) m_sts = 0;
        m_irq = fired;
    endtask

    task automatic cyc(input string tag, input bit e, input bit s, input bit p,
                       input bit c, input bit r, input logic [15:0] pr);
        ena = e; str = s; stp = p; clr = c; rpt = r; per = pr;
        @(posedge clk);
        #1;
        model_step(e, s, p, c, r, 32'(pr));
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a run
        cyc("rst_start", 0, 1, 0, 0, 0, 16'd10);
        for (int i = 0; i < 4; i++) cyc("rst_tick", 1, 0, 0, 0, 0, 16'd0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        #3;
        rst_n = 1'b1;
        cyc("rst_restart", 0, 1, 0, 0, 0, 16'd10);
        check("rst_restart.cnt10", 32'(cnt), 32'd10);
        cyc("rst_stop", 0, 0, 1, 0, 0, 16'd0);

        // One-shot, tick every 4th cycle
        cyc("os_start", 0, 1, 0, 0, 0, 16'd3);
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 3; k++) cyc("os_wait", 0, 0, 0, 0, 0, 16'd0);
            cyc("os_tick", 1, 0, 0, 0, 0, 16'd0);
        end
        check("os_irq_const", 32'(irq), 32'd1);
        cyc("os_done", 0, 0, 0, 0, 0, 16'd0);
        cyc("os_clr", 0, 0, 0, 1, 0, 16'd0);

        // Periodic per=2 with continuous ticks
        cyc("pd_start", 0, 1, 0, 0, 1, 16'd2);
        for (int i = 0; i < 10; i++) cyc("pd_tick", 1, 0, 0, 0, 0, 16'd0);
        cyc("pd_stop", 0, 0, 1, 0, 0, 16'd0);
        cyc("pd_clr", 0, 0, 0, 1, 0, 16'd0);

        // Collisions with the terminal tick
        cyc("sx_start", 0, 1, 0, 0, 0, 16'd2);
        cyc("sx_tick", 1, 0, 0, 0, 0, 16'd0);
        cyc("sx_stp_ena", 1, 0, 1, 0, 0, 16'd0);
        cyc("sx_start2", 0, 1, 0, 0, 0, 16'd2);
        cyc("sx_tick2", 1, 0, 0, 0, 0, 16'd0);
        cyc("sx_str_ena", 1, 1, 0, 0, 0, 16'd5);
        check("sx_str_ena.cnt5", 32'(cnt), 32'd5);
        cyc("sx_stop", 0, 0, 1, 0, 0, 16'd0);
        cyc("sx_start3", 0, 1, 0, 0, 0, 16'd2);
        cyc("sx_tick3", 1, 0, 0, 0, 0, 16'd0);
        cyc("sx_clr_exp", 1, 0, 0, 1, 0, 16'd0);
        check("sx_clr_exp.sts1", 32'(sts), 32'd1);
        cyc("sx_clr", 0, 0, 0, 1, 0, 16'd0);

        // Start with tick in IDLE: that tick is not counted
        cyc("it_str_ena", 1, 1, 0, 0, 0, 16'd2);
        cyc("it_tick", 1, 0, 0, 0, 0, 16'd0);
        cyc("it_tick", 1, 0, 0, 0, 0, 16'd0);
        cyc("it_clr", 0, 0, 0, 1, 0, 16'd0);

        // Zero period
        cyc("z_start", 0, 1, 0, 0, 0, 16'd0);
        check("z_irq_const", 32'(irq), 32'd1);
        cyc("z_after", 0, 0, 0, 0, 0, 16'd0);
        cyc("z_clr", 0, 0, 0, 1, 0, 16'd0);

        // Maximum period counts all the way down without wrapping
        cyc("max_start", 0, 1, 0, 0, 0, 16'hFFFF);
        for (int i = 0; i < 65535; i++) cyc("max_tick", 1, 0, 0, 0, 0, 16'd0);
        check("max_irq_const", 32'(irq), 32'd1);
        cyc("max_done", 1, 0, 0, 0, 0, 16'd0);
        cyc("max_clr", 0, 0, 0, 1, 0, 16'd0);

        // per=1 periodic: irq held high, one pulse per tick
        cyc("p1_start", 0, 1, 0, 0, 1, 16'd1);
        for (int i = 0; i < 6; i++) cyc("p1_tick", 1, 0, 0, 0, 0, 16'd0);
        cyc("p1_stop", 0, 0, 1, 0, 0, 16'd0);
        cyc("p1_clr", 0, 0, 0, 1, 0, 16'd0);

`ifdef TIMER_TICK_OVERRUN_EN
        cyc("ov_start", 0, 1, 0, 0, 1, 16'd1);
        cyc("ov_exp1", 1, 0, 0, 0, 0, 16'd0);
        cyc("ov_exp2", 1, 0, 0, 0, 0, 16'd0);
        check("ov_set_const", 32'(ovr), 32'd1);
        cyc("ov_clr", 0, 0, 0, 1, 0, 16'd0);
        cyc("ov_stop", 0, 0, 1, 0, 0, 16'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc("rnd",
                ($urandom_range(0, 1) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 29) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 1) == 1),
                16'($urandom_range(0, 6)));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/timer_tick.md
Name: timer_tick

Overview:
- Programmable one-shot/periodic down-counting timer, clocked by the tick pulse of an upstream wrap-on-maximum prescaler counter.
- The prescaler's last pulse drives this block's `ena`; one prescaler wrap equals one timer tick.
- Produces a registered expiry pulse, a sticky status flag and a remaining-tick count for the interrupt/status logic downstream.

Parameters:
- WIDTH, 16, width of period and remaining-tick counter.
- REPEAT_DEFAULT, 0, reset value of the internal mode register (0 one-shot, 1 periodic).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- ena  input  1  tick enable from upstream prescaler pulse; single-cycle per tick.
- str  input  1  start/restart pulse.
- stp  input  1  stop pulse; abort without expiry.
- clr  input  1  clear sticky status.
- rpt  input  1  mode, sampled with `str` (0 one-shot, 1 periodic).
- per  input  WIDTH  period in ticks, sampled with `str`.
- cnt  output  WIDTH  remaining ticks.
- bsy  output  1  timer running.
- irq  output  1  expiry pulse, one cycle.
- sts  output  1  sticky expiry flag.

Behaviour:
- Reset (rst_n low, async): state IDLE; cnt=0, bsy=0, irq=0, sts=0; per_reg=0; rpt_reg=REPEAT_DEFAULT.
- All outputs are registered.
- State IDLE (bsy=0, cnt=0):
  - `str` with per!=0: per_reg<=per, rpt_reg<=rpt, cnt<=per, go to RUN.
  - `str` with per==0: immediate expiry. irq=1 next cycle, sts<=1, state DONE (one-shot) or IDLE (periodic; zero period never runs).
- State RUN (bsy=1):
  - `ena` with cnt>1: cnt<=cnt-1.
  - `ena` with cnt==1: expiry. irq=1 next cycle, sts<=1.
    - Periodic: cnt<=per_reg, stay in RUN.
    - One-shot: cnt<=0, go to DONE.
  - Exactly per_reg ticks from start to irq.
  - Cycles without `ena` hold cnt.
- State DONE (bsy=0, cnt=0):
  - `str` behaves as in IDLE (restart).
  - `stp` or `clr` go to IDLE.
- Priority per cycle: stp > str > ena.
  - `stp` in RUN: go to IDLE, cnt<=0, no irq, even if `ena` with cnt==1 arrives in the same cycle.
  - `str` in RUN: restart with new per/rpt, tick ignored, no irq.
- `ena` and `str` in the same cycle while IDLE: the tick is not counted; counting begins with the next `ena`.
- sts:
  - Set on every expiry; cleared by `clr`.
  - Expiry and `clr` in the same cycle: set wins (sts=1).
  - `stp` does not clear sts.
- irq is exactly one cycle per expiry.
  - Back-to-back expiries in periodic mode with per_reg==1 and `ena` every cycle give irq high continuously, one pulse per tick.
- Arithmetic: unsigned, WIDTH bits.
  - per = 2^WIDTH-1 is legal.
  - Decrement never wraps, since cnt==1 is the terminal condition.
- Mid-operation reset: returns immediately to reset values; no irq is generated.

Optional Feature:
- Macro: TIMER_TICK_OVERRUN_EN.
- When defined:
  - Adds output `ovr`, 1 bit, reset 0.
  - `ovr` is set when an expiry occurs while sts is already 1 (unacknowledged previous expiry); cleared together with sts by `clr`.
  - Expiry and `clr` in the same cycle: sts=1, ovr=0.
- When undefined: no `ovr` port and no overrun logic; behaviour is otherwise identical.

Test Plan:
- Reset mid-RUN (per=10, after 4 ticks, pulse rst_n low) -> cnt=0, bsy=0, irq=0, sts=0 asynchronously; next `str` restarts cleanly.
- One-shot: per=3, str, then `ena` every 4th cycle -> cnt 3,2,1,0; irq one cycle after the 3rd tick; state DONE, bsy=0, sts=1; `clr` -> sts=0, state IDLE.
- Periodic: per=2, rpt=1, `ena` every cycle for 10 cycles -> irq every 2nd tick (5 pulses), cnt alternates 2,1, bsy stays 1; `stp` -> IDLE, cnt=0.
- Simultaneous events in RUN with cnt==1:
  - stp+ena -> no irq, IDLE.
  - str(per=5)+ena -> no irq, cnt=5.
  - clr+expiring ena -> sts=1.
- Edge periods:
  - per=0, str -> irq one cycle later, sts=1, DONE.
  - per=16'hFFFF -> counts 65535 ticks, no wrap.
  - per=1, rpt=1, continuous ena -> irq held high, one pulse per tick.
- TIMER_TICK_OVERRUN_EN defined: periodic per=1, two expiries without `clr` -> ovr=1 after the 2nd; `clr` -> sts=0, ovr=0.
